irq_controller: RTL and testbench

Interrupt controller for the cpuy core. It replaces the core's inline interrupt logic with one block that:
- synchronises the external interrupt pin and captures its edges,
- latches pending requests from the external pin, timer 0 and timer 1,
- applies the global and per-source enables from the CPU config register,
- arbitrates by fixed priority and hands one vector to the core through a request/ack/end-of-interrupt handshake.

It sits between the core's sequencer and the external pin and timers. It also drives the timers' done-ack inputs.

---
 rtl/cpuy_pkg.sv | 40 ++++
 rtl/sync_edge.sv | 27 ++
 rtl/irq_controller.sv | 142 ++++++++++++++
 tb/tb_irq_controller.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpuy_pkg.sv
// Shared cpuy definitions: cfg bit positions, interrupt source and controller state encodings,
// default vectors and a helper that resolves a source's effective enable.
package cpuy_pkg;

  localparam int CFG_GIE  = 7;
  localparam int CFG_EIE  = 6;
  localparam int CFG_T0IE = 5;
  localparam int CFG_T1IE = 4;

  localparam logic [11:0] EI_VECTOR_DEF = 12'h010;
  localparam logic [11:0] T0_VECTOR_DEF = 12'h020;
  localparam logic [11:0] T1_VECTOR_DEF = 12'h030;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_EI   = 2'd1,
    SRC_T0   = 2'd2,
    SRC_T1   = 2'd3
  } irq_src_e;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_REQUEST    = 2'd1,
    ST_IN_SERVICE = 2'd2
  } irq_state_e;

  // A source is usable only when both the global enable and its own enable are set.
  function automatic logic src_enabled(input logic [7:0] cfg, input irq_src_e src);
    logic en;
    en = 1'b0;
    unique case (src)
      SRC_EI:  en = cfg[CFG_EIE];
      SRC_T0:  en = cfg[CFG_T0IE];
      SRC_T1:  en = cfg[CFG_T1IE];
      default: en = 1'b0;
    endcase
    return cfg[CFG_GIE] & en;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin followed by a rising-edge detector.
// Latency: STAGES cycles to the synchronised level; the rise pulse is one cycle wide.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: latches EI/T0/T1 requests, applies cfg enables, fixed priority EI > T0 > T1,
// and offers one vector to the core via req/ack/eoi; pin-to-pending is SYNC_STAGES+1 cycles, req follows one cycle later.
module irq_controller
  import cpuy_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [11:0] EI_VECTOR   = EI_VECTOR_DEF,
  parameter logic [11:0] T0_VECTOR   = T0_VECTOR_DEF,
  parameter logic [11:0] T1_VECTOR   = T1_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ext_int,
  input  logic        t0_done,
  input  logic        t1_done,
  input  logic [7:0]  cfg,
  input  logic        irq_ack,
  input  logic        irq_eoi,
  output logic        irq_req,
  output logic [11:0] irq_vector,
  output logic [1:0]  irq_src,
  output logic        t0_done_ack,
  output logic        t1_done_ack,
  output logic [2:0]  pending
);

  irq_state_e  state_q, state_nxt;
  irq_src_e    src_q, src_nxt;
  logic [11:0] vector_q, vector_nxt;
  logic [2:0]  pending_q;
  logic [2:0]  eligible;
  logic        t0_ack_nxt, t1_ack_nxt;
  logic        ei_rise, ei_clr;
  logic        t0_in_service, t1_in_service;
  logic        unused_cfg_low;

  assign unused_cfg_low = ^cfg[3:0];

  sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_ei_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (ext_int),
    .rise (ei_rise)
  );

  assign eligible[0] = pending_q[0] & src_enabled(cfg, SRC_EI);
  assign eligible[1] = pending_q[1] & src_enabled(cfg, SRC_T0);
  assign eligible[2] = pending_q[2] & src_enabled(cfg, SRC_T1);

  assign t0_in_service = (state_q == ST_IN_SERVICE) && (src_q == SRC_T0);
  assign t1_in_service = (state_q == ST_IN_SERVICE) && (src_q == SRC_T1);

  always_comb begin
    state_nxt  = state_q;
    src_nxt    = src_q;
    vector_nxt = vector_q;
    t0_ack_nxt = 1'b0;
    t1_ack_nxt = 1'b0;
    ei_clr     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          state_nxt = ST_REQUEST;
          if (eligible[0]) begin
            src_nxt    = SRC_EI;
            vector_nxt = EI_VECTOR;
          end else if (eligible[1]) begin
            src_nxt    = SRC_T0;
            vector_nxt = T0_VECTOR;
          end else begin
            src_nxt    = SRC_T1;
            vector_nxt = T1_VECTOR;
          end
        end
      end
      ST_REQUEST: begin
        // An accept from the core takes precedence over a same-cycle enable drop.
        if (irq_ack) begin
          state_nxt = ST_IN_SERVICE;
          unique case (src_q)
            SRC_EI:  ei_clr     = 1'b1;
            SRC_T0:  t0_ack_nxt = 1'b1;
            SRC_T1:  t1_ack_nxt = 1'b1;
            default: ;
          endcase
        end else if (!src_enabled(cfg, src_q)) begin
          state_nxt  = ST_IDLE;
          src_nxt    = SRC_NONE;
          vector_nxt = '0;
        end
      end
      ST_IN_SERVICE: begin
        if (irq_eoi) begin
          state_nxt  = ST_IDLE;
          src_nxt    = SRC_NONE;
          vector_nxt = '0;
        end
      end
      default: begin
        state_nxt  = ST_IDLE;
        src_nxt    = SRC_NONE;
        vector_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      src_q       <= SRC_NONE;
      vector_q    <= '0;
      t0_done_ack <= 1'b0;
      t1_done_ack <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      src_q       <= src_nxt;
      vector_q    <= vector_nxt;
      t0_done_ack <= t0_ack_nxt;
      t1_done_ack <= t1_ack_nxt;
    end
  end

  // Timer pending bits track the done level, but are blanked while the ack is in flight
  // or the source is being serviced so a slow-to-drop done line cannot re-request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
    end else begin
      pending_q[0] <= ei_rise | (pending_q[0] & ~ei_clr);
      pending_q[1] <= t0_done & ~t0_done_ack & ~t0_in_service;
      pending_q[2] <= t1_done & ~t1_done_ack & ~t1_in_service;
    end
  end

  assign irq_req    = (state_q == ST_REQUEST);
  assign irq_src    = src_q;
  assign irq_vector = vector_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: vector table, directed corner sequences and random stimulus vs a behavioural model.
module tb_irq_controller;

  localparam int SS = 2;
  localparam logic lo = 1'b0;
  localparam logic hi = 1'b1;

  logic        clk;
  logic        rst;
  logic        ext_int, t0_done, t1_done, irq_ack, irq_eoi;
  logic [7:0]  cfg;
  logic        irq_req, t0_done_ack, t1_done_ack;
  logic [11:0] irq_vector;
  logic [1:0]  irq_src;
  logic [2:0]  pending;

  int n_checks = 0;
  int n_fail   = 0;

  irq_controller #(.SYNC_STAGES(SS)) dut (
    .clk         (clk),
    .rst         (rst),
    .ext_int     (ext_int),
    .t0_done     (t0_done),
    .t1_done     (t1_done),
    .cfg         (cfg),
    .irq_ack     (irq_ack),
    .irq_eoi     (irq_eoi),
    .irq_req     (irq_req),
    .irq_vector  (irq_vector),
    .irq_src     (irq_src),
    .t0_done_ack (t0_done_ack),
    .t1_done_ack (t1_done_ack),
    .pending     (pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  // Behavioural model: pin history as a queue, pending/ack flags indexed by source number (1=EI,2=T0,3=T1).
  bit         m_hist[$];
  logic [3:1] m_pend, m_ackp;
  logic       m_req, m_serv;
  int         m_src;

  function automatic logic [11:0] vec_of(input int s);
    return 12'(s * 16);
  endfunction

  function automatic void model_reset();
    m_hist.delete();
    for (int i = 0; i <= SS; i++) m_hist.push_back(1'b0);
    m_pend = '0;
    m_ackp = '0;
    m_req  = 1'b0;
    m_serv = 1'b0;
    m_src  = 0;
  endfunction

  function automatic void model_step();
    bit         rise, clr_ei;
    logic       gie;
    int         win;
    logic [3:1] np, nack;
    rise = m_hist[SS-1] && !m_hist[SS];
    m_hist.push_front(ext_int);
    void'(m_hist.pop_back());
    gie = cfg[7];
    win = 0;
    for (int s = 3; s >= 1; s--) if (m_pend[s] && gie && cfg[7-s]) win = s;
    clr_ei = 1'b0;
    nack   = '0;
    np[2]  = t0_done && !m_ackp[2] && !(m_serv && m_src == 2);
    np[3]  = t1_done && !m_ackp[3] && !(m_serv && m_src == 3);
    if (m_req) begin
      if (irq_ack) begin
        m_req  = 1'b0;
        m_serv = 1'b1;
        if (m_src == 1) clr_ei = 1'b1;
        else nack[m_src] = 1'b1;
      end else if (!(gie && cfg[7-m_src])) begin
        m_req = 1'b0;
        m_src = 0;
      end
    end else if (m_serv) begin
      if (irq_eoi) begin
        m_serv = 1'b0;
        m_src  = 0;
      end
    end else if (win != 0) begin
      m_req = 1'b1;
      m_src = win;
    end
    np[1]  = rise || (m_pend[1] && !clr_ei);
    m_pend = np;
    m_ackp = nack;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model req", 32'(irq_req), 32'(m_req));
    check("model src", 32'(irq_src), m_src);
    if (m_src != 0) check("model vector", 32'(irq_vector), 32'(vec_of(m_src)));
    check("model t0_ack", 32'(t0_done_ack), 32'(m_ackp[2]));
    check("model t1_ack", 32'(t1_done_ack), 32'(m_ackp[3]));
    check("model pending", 32'(pending), 32'(m_pend));
  endtask

  task automatic wait_req(input int max_cycles);
    bit got;
    got = 1'b0;
    for (int i = 0; i < max_cycles && !got; i++) begin
      if (irq_req) got = 1'b1;
      else tick();
    end
    if (irq_req) got = 1'b1;
    check("wait_req timeout", 32'(got), 32'd1);
  endtask

  typedef struct {
    logic        ext, t0, t1;
    logic [7:0]  c;
    logic        ack, eoi;
    logic        req;
    logic [1:0]  src;
    logic [11:0] vec;
    logic [2:0]  pend;
    logic        t0a, t1a;
  } vec_t;

  function automatic vec_t mk(input logic e, input logic a0, input logic a1, input logic [7:0] c,
                              input logic ak, input logic eo, input logic r, input logic [1:0] s,
                              input logic [11:0] v, input logic [2:0] p, input logic ta0, input logic ta1);
    vec_t t;
    t.ext = e;  t.t0 = a0; t.t1 = a1; t.c = c; t.ack = ak; t.eoi = eo;
    t.req = r;  t.src = s; t.vec = v; t.pend = p; t.t0a = ta0; t.t1a = ta1;
    return t;
  endfunction

  vec_t tbl[16];

  initial begin
    tbl[0]  = mk(hi, lo, lo, 8'hC0, lo, lo, lo, 2'd0, 12'h000, 3'b000, lo, lo);
    tbl[1]  = mk(lo, lo, lo, 8'hC0, lo, lo, lo, 2'd0, 12'h000, 3'b000, lo, lo);
    tbl[2]  = mk(lo, lo, lo, 8'hC0, lo, lo, lo, 2'd0, 12'h000, 3'b001, lo, lo);
    tbl[3]  = mk(lo, lo, lo, 8'hC0, lo, lo, hi, 2'd1, 12'h010, 3'b001, lo, lo);
    tbl[4]  = mk(lo, lo, lo, 8'hC0, lo, lo, hi, 2'd1, 12'h010, 3'b001, lo, lo);
    tbl[5]  = mk(lo, lo, lo, 8'hC0, hi, lo, lo, 2'd1, 12'h010, 3'b000, lo, lo);
    tbl[6]  = mk(lo, lo, lo, 8'hC0, lo, lo, lo, 2'd1, 12'h010, 3'b000, lo, lo);
    tbl[7]  = mk(lo, lo, lo, 8'hC0, lo, hi, lo, 2'd0, 12'h000, 3'b000, lo, lo);
    tbl[8]  = mk(lo, lo, lo, 8'hC0, lo, lo, lo, 2'd0, 12'h000, 3'b000, lo, lo);
    tbl[9]  = mk(lo, lo, hi, 8'hA0, lo, lo, lo, 2'd0, 12'h000, 3'b100, lo, lo);
    tbl[10] = mk(lo, lo, hi, 8'hA0, lo, lo, lo, 2'd0, 12'h000, 3'b100, lo, lo);
    tbl[11] = mk(lo, lo, hi, 8'h90, lo, lo, hi, 2'd3, 12'h030, 3'b100, lo, lo);
    tbl[12] = mk(lo, lo, hi, 8'h90, hi, lo, lo, 2'd3, 12'h030, 3'b100, lo, hi);
    tbl[13] = mk(lo, lo, lo, 8'h90, lo, lo, lo, 2'd3, 12'h030, 3'b000, lo, lo);
    tbl[14] = mk(lo, lo, lo, 8'h90, lo, hi, lo, 2'd0, 12'h000, 3'b000, lo, lo);
    tbl[15] = mk(lo, lo, lo, 8'h90, lo, lo, lo, 2'd0, 12'h000, 3'b000, lo, lo);

    rst = 1'b1; ext_int = 1'b0; t0_done = 1'b0; t1_done = 1'b0;
    cfg = 8'h00; irq_ack = 1'b0; irq_eoi = 1'b0;
    model_reset();
    #2 rst = 1'b0;
    #2;
    check("reset irq_req", 32'(irq_req), 32'd0);
    check("reset irq_vector", 32'(irq_vector), 32'h000);
    check("reset irq_src", 32'(irq_src), 32'd0);
    check("reset t0_done_ack", 32'(t0_done_ack), 32'd0);
    check("reset t1_done_ack", 32'(t1_done_ack), 32'd0);
    check("reset pending", 32'(pending), 32'd0);
    #14 rst = 1'b1;

    // Table: EI-only service, then T1 masked and unmasked.
    for (int i = 0; i < 16; i++) begin
      ext_int = tbl[i].ext; t0_done = tbl[i].t0; t1_done = tbl[i].t1;
      cfg = tbl[i].c; irq_ack = tbl[i].ack; irq_eoi = tbl[i].eoi;
      tick();
      check($sformatf("tbl[%0d] req", i), 32'(irq_req), 32'(tbl[i].req));
      check($sformatf("tbl[%0d] src", i), 32'(irq_src), 32'(tbl[i].src));
      if (tbl[i].src != 2'd0) check($sformatf("tbl[%0d] vector", i), 32'(irq_vector), 32'(tbl[i].vec));
      check($sformatf("tbl[%0d] pending", i), 32'(pending), 32'(tbl[i].pend));
      check($sformatf("tbl[%0d] t0_ack", i), 32'(t0_done_ack), 32'(tbl[i].t0a));
      check($sformatf("tbl[%0d] t1_ack", i), 32'(t1_done_ack), 32'(tbl[i].t1a));
    end
    irq_ack = 1'b0; irq_eoi = 1'b0;

    // Priority: all three pending bits land on the same edge.
    cfg = 8'hF0;
    ext_int = 1'b1; tick(); ext_int = 1'b0; tick();
    t0_done = 1'b1; t1_done = 1'b1; tick();
    check("prio pending all", 32'(pending), 32'b111);
    tick();
    check("prio first vector", 32'(irq_vector), 32'h010);
    check("prio first src", 32'(irq_src), 32'd1);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0; tick();
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0; tick();
    check("prio second req", 32'(irq_req), 32'd1);
    check("prio second vector", 32'(irq_vector), 32'h020);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("prio t0_done_ack pulse", 32'(t0_done_ack), 32'd1);
    t0_done = 1'b0; tick();
    check("prio t0_done_ack width", 32'(t0_done_ack), 32'd0);
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0; tick();
    check("prio third vector", 32'(irq_vector), 32'h030);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0; t1_done = 1'b0; tick();
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0; tick();

    // Withdraw: GIE drops while T0 is being offered.
    cfg = 8'hA0; t0_done = 1'b1;
    wait_req(5);
    check("withdraw src before", 32'(irq_src), 32'd2);
    cfg = 8'h20; tick();
    check("withdraw req", 32'(irq_req), 32'd0);
    check("withdraw src", 32'(irq_src), 32'd0);
    check("withdraw pending T0", 32'(pending[1]), 32'd1);
    check("withdraw no ack", 32'(t0_done_ack), 32'd0);
    tick();
    check("withdraw no ack later", 32'(t0_done_ack), 32'd0);
    t0_done = 1'b0; tick(); tick();

    // New EI edge during EI service is held until eoi.
    cfg = 8'hC0;
    ext_int = 1'b1; tick(); ext_int = 1'b0;
    wait_req(8);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    ext_int = 1'b1; tick(); ext_int = 1'b0; tick(); tick(); tick();
    check("service pending EI", 32'(pending[0]), 32'd1);
    check("service no req", 32'(irq_req), 32'd0);
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    check("after eoi idle", 32'(irq_req), 32'd0);
    tick();
    check("after eoi re-request", 32'(irq_req), 32'd1);
    check("after eoi src", 32'(irq_src), 32'd1);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0; tick();

    // Reset mid-service.
    cfg = 8'h90; t1_done = 1'b1;
    wait_req(5);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0; t1_done = 1'b0; tick();
    check("pre-reset src", 32'(irq_src), 32'd3);
    #3 rst = 1'b0;
    #1;
    model_reset();
    check("async reset src", 32'(irq_src), 32'd0);
    check("async reset vector", 32'(irq_vector), 32'd0);
    check("async reset req", 32'(irq_req), 32'd0);
    check("async reset pending", 32'(pending), 32'd0);
    check("async reset acks", 32'({t0_done_ack, t1_done_ack}), 32'd0);
    #2 rst = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("post-reset quiet", 32'(irq_req), 32'd0);

    // Random phase against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) ext_int = ~ext_int;
      if (!t0_done) t0_done = ($urandom_range(0, 9) == 0);
      else if (m_ackp[2]) t0_done = 1'b0;
      if (!t1_done) t1_done = ($urandom_range(0, 9) == 0);
      else if (m_ackp[3]) t1_done = 1'b0;
      if ($urandom_range(0, 19) == 0) cfg = {1'($urandom_range(0, 4) != 0), 7'($urandom)};
      irq_ack = m_req  ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
      irq_eoi = m_serv ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
